stp_fsm_param: RTL and testbench
================================

// Module: stp_fsm_param
// PURPOSE
//  Parametrised store-polynomial (STP) controller for the polynomial evaluation accelerator.
//  On start_stp, checks degree N, streams N+1 coefficients from the data buffer into slot A
//  of coefficient memory S, then writes N into degree memory at address A.
//  Adds input-stall handling, slot/degree generalisation, abort and error status.
// PARAMETERS
//  word_size    16    coefficient width (bits)
//  buffer_size  1024  data-buffer depth; read pointer wraps modulo buffer_size
//  num_slots    8     polynomial slots in S/N memories (power of 2)
//  max_degree   15    highest legal degree; slot stride SD = max_degree+1
// PORTS
//  clk                   in   1        clock, rising edge
//  rst                   in   1        synchronous, active-high reset
//  start_stp             in   1        start request, sampled in IDLE only
//  abort                 in   1        synchronous abort of current instruction
//  A                     in   log2(num_slots)         target slot, latched on start
//  N                     in   log2(max_degree+1)+1    requested degree, latched on start
//  rd_addr_data          in   log2(buffer_size)       data-buffer read pointer at start
//  data_in               in   word_size               coefficient at current read pointer
//  data_valid            in   1        data_in holds a valid word this cycle
//  en_rd_data            out  1        pop: word consumed this cycle
//  rd_addr_data_updated  out  log2(buffer_size)       read pointer after consumed words
//  en_wr_S / wr_addr_S   out  1 / log2(num_slots*SD)  coefficient write strobe / address
//  c                     out  word_size               coefficient write data
//  en_wr_N / wr_addr_N   out  1 / log2(num_slots)     degree write strobe / address
//  N_out                 out  log2(max_degree+1)+1    degree write data
//  busy / done_stp       out  1 / 1    instruction in flight / one-cycle completion pulse
//  result / status       out  32 / 32  coefficients written / status word
// BEHAVIOUR
//  Reset: state IDLE; every output 0; rd_addr_data_updated = 0.
//  States: IDLE -> CHECK -> LOAD -> WRITE_N -> DONE -> IDLE; CHECK -> DONE on error.
//  IDLE: start_stp=1 latches A, N, rd_addr_data; busy=1 from the next cycle. Start while busy ignored.
//  CHECK (1 cycle): N > max_degree -> status code 1 (BAD_DEGREE), no writes, go to DONE.
//  LOAD: per cycle with data_valid=1: en_rd_data=1, en_wr_S=1, c=data_in,
//   wr_addr_S = A*SD + k (k = 0..N), pointer += 1 mod buffer_size, k += 1.
//   data_valid=0 -> stall: no strobes, all state held. After k = N, go to WRITE_N.
//   Combinational pass-through data_in -> c; same-cycle pop (first-word-fall-through source).
//  WRITE_N (1 cycle): en_wr_N=1, wr_addr_N=A, N_out=N.
//  DONE (1 cycle): done_stp=1, busy=0 next cycle. result = coefficients written (N+1 on success).
//  status[1:0]: 0 OK, 1 BAD_DEGREE, 2 ABORTED; status[15:8] = A; other bits 0.
//   result/status hold until next start.
//  abort=1 in CHECK/LOAD/WRITE_N: go to DONE with code 2. Degree memory is not written,
//   so the slot keeps its old degree. Coefficients already written stay. Pointer reflects words consumed.
//  abort in IDLE or DONE: ignored. rst overrides abort and start in the same cycle.
//  N=0: exactly one coefficient. Read-pointer wrap: buffer_size-1 -> 0 with no bubble.
//  Minimum latency for N: N+4 cycles from start to done_stp (no stalls).
// STRUCTURE
//  stp_pkg: state encoding, status codes (STP_OK/BAD_DEGREE/ABORTED), log2 function.
//  Sub-module stp_coef_addr_gen: coefficient counter k, slot base A*SD, wr_addr_S,
//   wrapping read pointer; advances on en_rd_data.
// TESTING
//  1. A=0, N=3, ptr=0, data 2,1,4,7 always valid -> S[0..3]=2,1,4,7; N_mem[0]=3;
//     done at cycle 7; result=4; status=0; ptr=4.
//  2. A=5, N=2, data_valid low on every 2nd cycle -> writes to S[80..82] only on valid cycles;
//     no strobes on stall cycles; result=3.
//  3. N=16 (max_degree=15) -> no en_wr_S/en_wr_N; done 2 cycles after start;
//     status=0x0000_0?01 with A in [15:8]; result=0.
//  4. ptr=1022, N=3 -> reads 1022, 1023, 0, 1; rd_addr_data_updated=2.
//  5. abort after 2 coefficients of N=5 -> status code 2; result=2; N_mem unchanged;
//     next start_stp is accepted normally.
//  6. rst asserted mid-LOAD -> next cycle IDLE with all outputs 0;
//     start_stp held high during busy is ignored.

Source files
------------

// File: rtl/stp_pkg.sv
// Shared definitions for the store-polynomial (STP) controller.
//   - stp_state_e : controller state encoding
//   - STP_*       : completion codes reported in status[1:0]
//   - stp_log2    : ceiling log2 used to size ports from the parameters
//   - make_status : packs a completion code and slot number into the status word
package stp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_WRITE_N = 3'd3,
        ST_DONE    = 3'd4
    } stp_state_e;

    localparam logic [1:0] STP_OK         = 2'd0;
    localparam logic [1:0] STP_BAD_DEGREE = 2'd1;
    localparam logic [1:0] STP_ABORTED    = 2'd2;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int stp_log2(input int value);
        int result_v;
        result_v = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result_v = i + 1;
            end else begin
                result_v = result_v;
            end
        end
        return result_v;
    endfunction

    // status layout: [15:8] slot, [1:0] completion code, all other bits zero.
    function automatic logic [31:0] make_status(input logic [1:0] code,
                                                input logic [7:0] slot);
        return {16'h0000, slot, 6'b000000, code};
    endfunction

endpackage

// File: rtl/stp_coef_addr_gen.sv
// Coefficient address generator for the STP controller.
// Holds the coefficient index k, the slot base address A*SD and the data-buffer
// read pointer. 'load' captures a new slot/pointer and clears k; 'advance'
// (one consumed word) bumps k and the pointer, which wraps at buffer_size.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         capture a_in/ptr_in, clear k
//   advance      one coefficient consumed this cycle
//   a_in         target slot
//   ptr_in       starting read pointer
//   k_out        coefficients consumed so far
//   wr_addr_s    coefficient-memory address of the current word (base + k)
//   ptr_out      current read pointer
module stp_coef_addr_gen #(
    parameter int a_w         = 3,
    parameter int n_w         = 5,
    parameter int ptr_w       = 10,
    parameter int s_addr_w    = 7,
    parameter int sd          = 16,
    parameter int buffer_size = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                advance,
    input  logic [a_w-1:0]      a_in,
    input  logic [ptr_w-1:0]    ptr_in,
    output logic [n_w-1:0]      k_out,
    output logic [s_addr_w-1:0] wr_addr_s,
    output logic [ptr_w-1:0]    ptr_out
);

    localparam logic [ptr_w-1:0] ptr_last = ptr_w'(buffer_size - 1);

    logic [n_w-1:0]      k_q,    k_d;
    logic [s_addr_w-1:0] base_q, base_d;
    logic [ptr_w-1:0]    ptr_q,  ptr_d;

    // Counter, slot base and read-pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q    <= '0;
            base_q <= '0;
            ptr_q  <= '0;
        end else begin
            k_q    <= k_d;
            base_q <= base_d;
            ptr_q  <= ptr_d;
        end
    end

    // Next-state: load a new instruction, or step on each consumed word.
    always_comb begin
        k_d    = k_q;
        base_d = base_q;
        ptr_d  = ptr_q;
        if (load) begin
            k_d    = '0;
            base_d = s_addr_w'(a_in) * s_addr_w'(sd);
            ptr_d  = ptr_in;
        end else if (advance) begin
            k_d = k_q + n_w'(1);
            // Explicit wrap so non-power-of-two buffer depths also work.
            if (ptr_q == ptr_last) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + ptr_w'(1);
            end
        end else begin
            k_d = k_q;
        end
    end

    assign k_out     = k_q;
    assign wr_addr_s = base_q + s_addr_w'(k_q);
    assign ptr_out   = ptr_q;

endmodule

// File: rtl/stp_fsm_param.sv
// Store-polynomial controller. On start_stp it latches slot A, degree N and the
// buffer read pointer, rejects degrees above max_degree, streams N+1
// coefficients from a first-word-fall-through buffer into slot A of the
// coefficient memory (stalling while data_valid is low), writes N into the
// degree memory and pulses done_stp. abort ends the instruction early without
// touching the degree memory.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start_stp, abort       start request (IDLE only) / early termination
//   A, N, rd_addr_data     slot, degree, starting read pointer (latched on start)
//   data_in, data_valid    buffer word at the read pointer and its valid flag
//   en_rd_data             pop strobe, same cycle as the word is used
//   rd_addr_data_updated   read pointer after consumed words
//   en_wr_S/wr_addr_S/c    coefficient memory write port
//   en_wr_N/wr_addr_N/N_out degree memory write port
//   busy, done_stp         in flight / one-cycle completion pulse
//   result, status         coefficients written / code + slot, held until next start
module stp_fsm_param
    import stp_pkg::*;
#(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024,
    parameter int num_slots   = 8,
    parameter int max_degree  = 15
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start_stp,
    input  logic                                          abort,
    input  logic [stp_log2(num_slots)-1:0]                A,
    input  logic [stp_log2(max_degree+1):0]               N,
    input  logic [stp_log2(buffer_size)-1:0]              rd_addr_data,
    input  logic [word_size-1:0]                          data_in,
    input  logic                                          data_valid,
    output logic                                          en_rd_data,
    output logic [stp_log2(buffer_size)-1:0]              rd_addr_data_updated,
    output logic                                          en_wr_S,
    output logic [stp_log2(num_slots*(max_degree+1))-1:0] wr_addr_S,
    output logic [word_size-1:0]                          c,
    output logic                                          en_wr_N,
    output logic [stp_log2(num_slots)-1:0]                wr_addr_N,
    output logic [stp_log2(max_degree+1):0]               N_out,
    output logic                                          busy,
    output logic                                          done_stp,
    output logic [31:0]                                   result,
    output logic [31:0]                                   status
);

    localparam int a_w      = stp_log2(num_slots);
    localparam int n_w      = stp_log2(max_degree + 1) + 1;
    localparam int ptr_w    = stp_log2(buffer_size);
    localparam int sd       = max_degree + 1;
    localparam int s_addr_w = stp_log2(num_slots * sd);

    localparam logic [n_w-1:0] max_deg_c = n_w'(max_degree);

    stp_state_e          state_q,  state_d;
    logic [a_w-1:0]      a_q,      a_d;
    logic [n_w-1:0]      n_q,      n_d;
    logic [31:0]         result_q, result_d;
    logic [31:0]         status_q, status_d;

    logic                load_s;
    logic [n_w-1:0]      k_s;
    logic [s_addr_w-1:0] addr_s;
    logic [ptr_w-1:0]    ptr_s;
    logic                last_s;

    stp_coef_addr_gen #(
        .a_w        (a_w),
        .n_w        (n_w),
        .ptr_w      (ptr_w),
        .s_addr_w   (s_addr_w),
        .sd         (sd),
        .buffer_size(buffer_size)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .advance   (en_rd_data),
        .a_in      (A),
        .ptr_in    (rd_addr_data),
        .k_out     (k_s),
        .wr_addr_s (addr_s),
        .ptr_out   (ptr_s)
    );

    // The word being consumed now is coefficient N, i.e. the final one.
    assign last_s               = (k_s == n_q);
    assign rd_addr_data_updated = ptr_s;
    assign result               = result_q;
    assign status               = status_q;

    // State, latched instruction fields and completion registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            n_q      <= '0;
            result_q <= 32'd0;
            status_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            n_q      <= n_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    // Next-state and output decode; abort takes priority over any strobe.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        n_d        = n_q;
        result_d   = result_q;
        status_d   = status_q;
        load_s     = 1'b0;
        en_rd_data = 1'b0;
        en_wr_S    = 1'b0;
        wr_addr_S  = '0;
        c          = '0;
        en_wr_N    = 1'b0;
        wr_addr_N  = '0;
        N_out      = '0;
        busy       = (state_q != ST_IDLE);
        done_stp   = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start_stp) begin
                    state_d  = ST_CHECK;
                    a_d      = A;
                    n_d      = N;
                    load_s   = 1'b1;
                    result_d = 32'd0;
                    status_d = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CHECK: begin
                if (abort) begin
                    state_d  = ST_DONE;
                    result_d = 32'd0;
                    status_d = make_status(STP_ABORTED, 8'(a_q));
                end else if (n_q > max_deg_c) begin
                    state_d  = ST_DONE;
                    result_d = 32'd0;
                    status_d = make_status(STP_BAD_DEGREE, 8'(a_q));
                end else begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    state_d  = ST_DONE;
                    result_d = 32'(k_s);
                    status_d = make_status(STP_ABORTED, 8'(a_q));
                end else if (data_valid) begin
                    en_rd_data = 1'b1;
                    en_wr_S    = 1'b1;
                    wr_addr_S  = addr_s;
                    c          = data_in;
                    if (last_s) begin
                        state_d = ST_WRITE_N;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end

            ST_WRITE_N: begin
                if (abort) begin
                    // Degree memory is left untouched so the slot keeps its old degree.
                    state_d  = ST_DONE;
                    result_d = 32'(k_s);
                    status_d = make_status(STP_ABORTED, 8'(a_q));
                end else begin
                    en_wr_N   = 1'b1;
                    wr_addr_N = a_q;
                    N_out     = n_q;
                    state_d   = ST_DONE;
                    result_d  = 32'(k_s);
                    status_d  = make_status(STP_OK, 8'(a_q));
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stp_fsm_param.sv
module tb_stp_fsm_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_stp;
    logic        abort;
    logic [2:0]  A;
    logic [4:0]  N;
    logic [9:0]  rd_addr_data;
    logic [15:0] data_in;
    logic        data_valid;
    logic        en_rd_data;
    logic [9:0]  rd_addr_data_updated;
    logic        en_wr_S;
    logic [6:0]  wr_addr_S;
    logic [15:0] c;
    logic        en_wr_N;
    logic [2:0]  wr_addr_N;
    logic [4:0]  N_out;
    logic        busy;
    logic        done_stp;
    logic [31:0] result;
    logic [31:0] status;

    logic [15:0] buf_mem [1024];
    int          n_obs [8];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // First-word-fall-through buffer: word at the DUT's current read pointer.
    assign data_in = buf_mem[rd_addr_data_updated];

    stp_fsm_param dut (
        .clk                  (clk),
        .rst                  (rst),
        .start_stp            (start_stp),
        .abort                (abort),
        .A                    (A),
        .N                    (N),
        .rd_addr_data         (rd_addr_data),
        .data_in              (data_in),
        .data_valid           (data_valid),
        .en_rd_data           (en_rd_data),
        .rd_addr_data_updated (rd_addr_data_updated),
        .en_wr_S              (en_wr_S),
        .wr_addr_S            (wr_addr_S),
        .c                    (c),
        .en_wr_N              (en_wr_N),
        .wr_addr_N            (wr_addr_N),
        .N_out                (N_out),
        .busy                 (busy),
        .done_stp             (done_stp),
        .result               (result),
        .status               (status)
    );

    // One instruction. stall_mode: 0 always valid, 1 valid every other cycle,
    // 2 random. abort_after >= 0 aborts once that many coefficients were written.
    task automatic run_instr(input int a, input int n, input int ptr,
                             input int stall_mode, input int abort_after,
                             input bit hold_start);
        int exp_addr[$];
        int exp_data[$];
        int nwr, code, exp_stat, exp_ptr, exp_lat, exp_nmem;
        int writes, nwrites_n, cyc, done_cyc;
        bit abort_fired;

        // Reference model from the instruction's rules.
        if (n > 15) begin
            nwr = 0; code = 1; exp_lat = 2;
        end else begin
            nwr     = (abort_after >= 0) ? abort_after : n + 1;
            code    = (abort_after >= 0) ? 2 : 0;
            exp_lat = n + 4;
        end
        for (int k = 0; k < nwr; k++) begin
            exp_addr.push_back(a * 16 + k);
            exp_data.push_back(int'(buf_mem[(ptr + k) % 1024]));
        end
        exp_stat = code + a * 256;
        exp_ptr  = (ptr + nwr) % 1024;
        exp_nmem = (code == 0) ? n : n_obs[a];

        @(posedge clk); #1;
        start_stp    = 1'b1;
        A            = 3'(a);
        N            = 5'(n);
        rd_addr_data = 10'(ptr);
        data_valid   = 1'b0;
        abort        = 1'b0;
        writes = 0; nwrites_n = 0; cyc = 0; done_cyc = -1; abort_fired = 1'b0;

        while (done_cyc < 0 && cyc < 400) begin
            @(posedge clk); #1;
            if (hold_start) begin
                start_stp    = 1'b1;
                A            = 3'($urandom);
                N            = 5'($urandom);
                rd_addr_data = 10'($urandom);
            end else begin
                start_stp = 1'b0;
            end
            abort = 1'b0;
            if (abort_after >= 0 && !abort_fired && writes == abort_after) begin
                abort       = 1'b1;
                abort_fired = 1'b1;
                data_valid  = 1'b0;
            end else begin
                case (stall_mode)
                    0:       data_valid = 1'b1;
                    1:       data_valid = ((cyc % 2) == 1);
                    default: data_valid = ($urandom_range(0, 2) != 0);
                endcase
            end
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (busy !== 1'b1) $display("FAIL busy_after_start got %0b want 1", busy);
                if (busy !== 1'b1) errors++;
            end
            checks++;
            if ((!data_valid && (en_wr_S || en_rd_data)) || (en_rd_data !== en_wr_S)) begin
                errors++;
                $display("FAIL strobe_gating cyc %0d valid %0b got rd %0b wrS %0b", cyc, data_valid, en_rd_data, en_wr_S);
            end
            if (en_wr_S === 1'b1) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL extra_coef_write got addr %0d want no write", wr_addr_S);
                end else begin
                    if (32'(wr_addr_S) !== exp_addr[0] || 32'(c) !== exp_data[0]) begin
                        errors++;
                        $display("FAIL coef_write got addr %0d data %0d want addr %0d data %0d",
                                 wr_addr_S, c, exp_addr[0], exp_data[0]);
                    end
                    void'(exp_addr.pop_front());
                    void'(exp_data.pop_front());
                end
                writes++;
            end
            if (en_wr_N === 1'b1) begin
                checks++;
                nwrites_n++;
                if (code != 0 || 32'(wr_addr_N) !== a || 32'(N_out) !== n) begin
                    errors++;
                    $display("FAIL degree_write got addr %0d N %0d want addr %0d N %0d code %0d",
                             wr_addr_N, N_out, a, n, code);
                end
                n_obs[wr_addr_N] = int'(N_out);
            end
            if (done_stp === 1'b1) done_cyc = cyc;
        end

        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout got none want done within 400 cycles");
        end
        checks++;
        if (exp_addr.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d writes want %0d", writes, nwr);
        end
        if (stall_mode == 0 && abort_after < 0) begin
            checks++;
            if (done_cyc != exp_lat) begin
                errors++;
                $display("FAIL latency got %0d want %0d", done_cyc, exp_lat);
            end
        end
        checks++;
        if (result !== 32'(nwr)) begin
            errors++;
            $display("FAIL result got %0d want %0d", result, nwr);
        end
        checks++;
        if (status !== 32'(exp_stat)) begin
            errors++;
            $display("FAIL status got %h want %h", status, exp_stat);
        end
        checks++;
        if (32'(rd_addr_data_updated) !== exp_ptr) begin
            errors++;
            $display("FAIL read_pointer got %0d want %0d", rd_addr_data_updated, exp_ptr);
        end
        checks++;
        if (nwrites_n != ((code == 0) ? 1 : 0) || n_obs[a] != exp_nmem) begin
            errors++;
            $display("FAIL degree_mem got writes %0d value %0d want value %0d", nwrites_n, n_obs[a], exp_nmem);
        end

        @(posedge clk); #1;
        start_stp  = 1'b0;
        abort      = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_stp !== 1'b0 || result !== 32'(nwr)) begin
            errors++;
            $display("FAIL after_done got busy %0b done %0b result %0d want 0 0 %0d", busy, done_stp, result, nwr);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (busy !== 1'b0 || done_stp !== 1'b0 || en_rd_data !== 1'b0 || en_wr_S !== 1'b0 ||
            wr_addr_S !== 7'd0 || c !== 16'd0 || en_wr_N !== 1'b0 || wr_addr_N !== 3'd0 ||
            N_out !== 5'd0 || result !== 32'd0 || status !== 32'd0 || rd_addr_data_updated !== 10'd0) begin
            errors++;
            $display("FAIL %s got busy %0b done %0b rd %0b wrS %0b aS %0d c %0d wrN %0b aN %0d No %0d res %0d st %h ptr %0d want all 0",
                     tag, busy, done_stp, en_rd_data, en_wr_S, wr_addr_S, c, en_wr_N, wr_addr_N,
                     N_out, result, status, rd_addr_data_updated);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_stp = 1'b0; abort = 1'b0; data_valid = 1'b0;
        A = 3'd0; N = 5'd0; rd_addr_data = 10'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");
    endtask

    task automatic test_basic();
        buf_mem[0] = 16'd2; buf_mem[1] = 16'd1; buf_mem[2] = 16'd4; buf_mem[3] = 16'd7;
        run_instr(0, 3, 0, 0, -1, 1'b0);
    endtask

    task automatic test_stall();
        run_instr(5, 2, 40, 1, -1, 1'b0);
    endtask

    task automatic test_bad_degree();
        run_instr(6, 16, 200, 0, -1, 1'b0);
    endtask

    task automatic test_wrap();
        run_instr(4, 3, 1022, 0, -1, 1'b0);
    endtask

    task automatic test_abort();
        run_instr(2, 7, 300, 0, -1, 1'b0);
        run_instr(2, 5, 310, 0, 2, 1'b0);
        run_instr(2, 4, 320, 0, -1, 1'b0);
    endtask

    task automatic test_degree_zero();
        run_instr(7, 0, 500, 0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        @(posedge clk); #1;
        start_stp = 1'b1; A = 3'd1; N = 5'd10; rd_addr_data = 10'd600; data_valid = 1'b1;
        @(posedge clk); #1 start_stp = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; start_stp = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_stp = 1'b0; abort = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        check_all_zero("reset_mid_load");
        run_instr(3, 4, 100, 0, -1, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            int a, n, ptr, ab;
            a   = $urandom_range(0, 7);
            n   = $urandom_range(0, 16);
            ptr = $urandom_range(0, 1023);
            ab  = -1;
            if (n <= 15 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, n);
            run_instr(a, n, ptr, 2, ab, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) buf_mem[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) n_obs[i] = -1;
        test_reset();
        test_basic();
        test_stall();
        test_bad_degree();
        test_wrap();
        test_abort();
        test_degree_zero();
        test_reset_mid_load();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
